wordcount_read_scheduler: RTL and testbench

- Control-side scheduler for the wordcount kernel's m00 AXI read path.
- On ap_start, latches command, data_num and axi00_ptr0, then splits data_num 512-bit beats into AR bursts.
- Bounds the number of outstanding bursts and tracks returned beats and rlast.
- Signals ap_done once every burst has fully returned. Sits between the kernel control interface and the m00 AR channel; R data itself flows straight to the datapath.

---
 rtl/wordcount_read_scheduler.sv | 186 ++++++++++++++++++
 tb/tb_wordcount_read_scheduler.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/wordcount_read_scheduler.sv
// AR-side scheduler for the wordcount m00 read path: splits a beat count into bursts,
// bounds the number of outstanding bursts and reports completion once every rlast returns.
module wordcount_read_scheduler #(
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 64,
    parameter int unsigned C_M_AXI_DATA_WIDTH = 512,
    parameter int unsigned C_MAX_BURST_LEN    = 64,
    parameter int unsigned C_MAX_OUTSTANDING  = 4
) (
    input  logic                          ap_clk,
    input  logic                          ap_rst,
    input  logic                          ap_start,
    output logic                          ap_idle,
    output logic                          ap_done,
    input  logic [31:0]                   command,
    input  logic [31:0]                   data_num,
    input  logic [63:0]                   axi00_ptr0,
    output logic [31:0]                   cmd_q,
    output logic                          m00_axi_arvalid,
    input  logic                          m00_axi_arready,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] m00_axi_araddr,
    output logic [7:0]                    m00_axi_arlen,
    input  logic                          m00_axi_rvalid,
    input  logic                          m00_axi_rready,
    input  logic                          m00_axi_rlast,
    output logic [31:0]                   beats_rcvd,
    output logic                          err_rlast
);

    localparam int unsigned AW           = C_M_AXI_ADDR_WIDTH;
    localparam int unsigned BytesPerBeat = C_M_AXI_DATA_WIDTH / 8;
    localparam int unsigned OutW         = $clog2(C_MAX_OUTSTANDING + 1);
    localparam logic [OutW-1:0] MaxOut   = OutW'(C_MAX_OUTSTANDING);
    localparam logic [31:0] MaxBurst     = 32'(C_MAX_BURST_LEN);
    localparam logic [7:0] MaxArlen      = 8'(C_MAX_BURST_LEN - 1);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain,
        StDone
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       remaining_q, remaining_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [OutW-1:0]   outstanding_q, outstanding_d;
    logic              arvalid_q, arvalid_d;
    logic [AW-1:0]     araddr_q, araddr_d;
    logic [7:0]        arlen_q, arlen_d;
    logic [31:0]       cmd_latched_q, cmd_latched_d;
    logic [31:0]       beats_q, beats_d;
    logic              err_q, err_d;

    logic              r_beat;
    logic              r_last;
    logic              ar_hs;
    logic              dec;
    logic [8:0]        burst_beats;
    logic [AW-1:0]     burst_bytes;
    logic [31:0]       remaining_after;
    logic [AW-1:0]     addr_after;
    logic [7:0]        next_arlen;

    assign r_beat      = (state_q != StIdle) && m00_axi_rvalid && m00_axi_rready;
    assign r_last      = r_beat && m00_axi_rlast;
    assign ar_hs       = arvalid_q && m00_axi_arready;
    // An rlast with nothing outstanding is flagged, never allowed to underflow the counter.
    assign dec         = r_last && (outstanding_q != '0);
    assign burst_beats = {1'b0, arlen_q} + 9'd1;
    assign burst_bytes = AW'(burst_beats) * AW'(BytesPerBeat);

    always_comb begin
        remaining_after = remaining_q;
        addr_after      = addr_q;
        if (ar_hs) begin
            remaining_after = remaining_q - 32'(burst_beats);
            addr_after      = addr_q + burst_bytes;
        end
    end

    always_comb begin
        next_arlen = MaxArlen;
        if (remaining_after <= MaxBurst) begin
            next_arlen = 8'(remaining_after - 32'd1);
        end
    end

    always_comb begin
        outstanding_d = outstanding_q;
        if (ar_hs && !dec) begin
            outstanding_d = outstanding_q + OutW'(1);
        end else if (!ar_hs && dec) begin
            outstanding_d = outstanding_q - OutW'(1);
        end
    end

    always_comb begin
        state_d       = state_q;
        remaining_d   = remaining_q;
        addr_d        = addr_q;
        arvalid_d     = arvalid_q;
        araddr_d      = araddr_q;
        arlen_d       = arlen_q;
        cmd_latched_d = cmd_latched_q;
        beats_d       = r_beat ? beats_q + 32'd1 : beats_q;
        err_d         = err_q | (r_last && (outstanding_q == '0));

        unique case (state_q)
            StIdle: begin
                arvalid_d = 1'b0;
                if (ap_start) begin
                    cmd_latched_d = command;
                    remaining_d   = data_num;
                    addr_d        = AW'(axi00_ptr0);
                    beats_d       = '0;
                    err_d         = 1'b0;
                    state_d       = (data_num == '0) ? StDone : StIssue;
                end
            end
            StIssue: begin
                remaining_d = remaining_after;
                addr_d      = addr_after;
                if (remaining_after == '0) begin
                    arvalid_d = 1'b0;
                    state_d   = StDrain;
                end else if (!arvalid_q || ar_hs) begin
                    // A presented burst is held until accepted; only load a new one when free.
                    arvalid_d = (outstanding_d < MaxOut);
                    if (outstanding_d < MaxOut) begin
                        araddr_d = addr_after;
                        arlen_d  = next_arlen;
                    end
                end
            end
            StDrain: begin
                arvalid_d = 1'b0;
                if (outstanding_d == '0) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                arvalid_d = 1'b0;
                state_d   = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q       <= StIdle;
            remaining_q   <= '0;
            addr_q        <= '0;
            outstanding_q <= '0;
            arvalid_q     <= 1'b0;
            araddr_q      <= '0;
            arlen_q       <= '0;
            cmd_latched_q <= '0;
            beats_q       <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            remaining_q   <= remaining_d;
            addr_q        <= addr_d;
            outstanding_q <= outstanding_d;
            arvalid_q     <= arvalid_d;
            araddr_q      <= araddr_d;
            arlen_q       <= arlen_d;
            cmd_latched_q <= cmd_latched_d;
            beats_q       <= beats_d;
            err_q         <= err_d;
        end
    end

    assign ap_idle         = (state_q == StIdle);
    assign ap_done         = (state_q == StDone);
    assign cmd_q           = cmd_latched_q;
    assign m00_axi_arvalid = arvalid_q;
    assign m00_axi_araddr  = araddr_q;
    assign m00_axi_arlen   = arlen_q;
    assign beats_rcvd      = beats_q;
    assign err_rlast       = err_q;

endmodule

// File: tb/tb_wordcount_read_scheduler.sv
// Directed bench for wordcount_read_scheduler: zero-length, split bursts, outstanding limit,
// AR back-pressure, ignored start, stray rlast and mid-drain reset.
module tb_wordcount_read_scheduler;

    logic        ap_clk = 1'b0;
    logic        ap_rst;
    logic        ap_start;
    logic        ap_idle;
    logic        ap_done;
    logic [31:0] command;
    logic [31:0] data_num;
    logic [63:0] axi00_ptr0;
    logic [31:0] cmd_q;
    logic        arvalid;
    logic        arready;
    logic [63:0] araddr;
    logic [7:0]  arlen;
    logic        rvalid;
    logic        rready;
    logic        rlast;
    logic [31:0] beats_rcvd;
    logic        err_rlast;

    int vectors    = 0;
    int miscompares = 0;
    int hs_cnt     = 0;
    int done_cnt   = 0;

    localparam logic [63:0] P4 = 64'h0001_0000;

    wordcount_read_scheduler dut (
        .ap_clk          (ap_clk),
        .ap_rst          (ap_rst),
        .ap_start        (ap_start),
        .ap_idle         (ap_idle),
        .ap_done         (ap_done),
        .command         (command),
        .data_num        (data_num),
        .axi00_ptr0      (axi00_ptr0),
        .cmd_q           (cmd_q),
        .m00_axi_arvalid (arvalid),
        .m00_axi_arready (arready),
        .m00_axi_araddr  (araddr),
        .m00_axi_arlen   (arlen),
        .m00_axi_rvalid  (rvalid),
        .m00_axi_rready  (rready),
        .m00_axi_rlast   (rlast),
        .beats_rcvd      (beats_rcvd),
        .err_rlast       (err_rlast)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Counts AR handshakes before the edge and ap_done pulses after it; samples 1 time unit late.
    task automatic step();
        if (arvalid && arready) hs_cnt++;
        @(posedge ap_clk);
        #1;
        if (ap_done) done_cnt++;
    endtask

    task automatic r_set(input logic v, input logic l);
        rvalid = v;
        rready = v;
        rlast  = l;
    endtask

    initial begin
        ap_rst = 1'b1; ap_start = 1'b0; command = '0; data_num = '0; axi00_ptr0 = '0;
        arready = 1'b0; rvalid = 1'b0; rready = 1'b0; rlast = 1'b0;
        step(); step();
        ap_rst = 1'b0;
        step();
        check("rst_idle", 64'(ap_idle), 64'd1);
        check("rst_done", 64'(ap_done), 64'd0);
        check("rst_arvalid", 64'(arvalid), 64'd0);
        check("rst_araddr", araddr, 64'd0);
        check("rst_arlen", 64'(arlen), 64'd0);
        check("rst_cmd", 64'(cmd_q), 64'd0);
        check("rst_beats", 64'(beats_rcvd), 64'd0);
        check("rst_err", 64'(err_rlast), 64'd0);

        // Zero-length transfer
        ap_start = 1'b1; command = 32'h0000_00A5; data_num = 32'd0;
        step();
        ap_start = 1'b0;
        check("z_done", 64'(ap_done), 64'd1);
        check("z_idle", 64'(ap_idle), 64'd0);
        check("z_arvalid", 64'(arvalid), 64'd0);
        check("z_cmd", 64'(cmd_q), 64'h A5);
        step();
        check("z_done_end", 64'(ap_done), 64'd0);
        check("z_idle_back", 64'(ap_idle), 64'd1);

        // 100 beats from 0x1000: 64-beat burst then 36-beat burst
        hs_cnt = 0; done_cnt = 0;
        ap_start = 1'b1; command = 32'h1111_0001; data_num = 32'd100; axi00_ptr0 = 64'h1000;
        arready = 1'b1;
        step();
        ap_start = 1'b0;
        check("b_first_gap", 64'(arvalid), 64'd0);
        step();
        check("b1_valid", 64'(arvalid), 64'd1);
        check("b1_addr", araddr, 64'h1000);
        check("b1_len", 64'(arlen), 64'd63);
        step();
        check("b2_valid", 64'(arvalid), 64'd1);
        check("b2_addr", araddr, 64'h2000);
        check("b2_len", 64'(arlen), 64'd35);
        step();
        check("b_drain_arvalid", 64'(arvalid), 64'd0);
        check("b_hs", 64'(hs_cnt), 64'd2);
        arready = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            r_set(1'b1, (i == 64) || (i == 100));
            step();
        end
        check("b_done_now", 64'(ap_done), 64'd1);
        r_set(1'b0, 1'b0);
        step(); step();
        check("b_done_cnt", 64'(done_cnt), 64'd1);
        check("b_beats", 64'(beats_rcvd), 64'd100);
        check("b_idle", 64'(ap_idle), 64'd1);
        check("b_err", 64'(err_rlast), 64'd0);

        // 512 beats, limit of 4 outstanding; stray rlast before any burst is issued
        hs_cnt = 0; done_cnt = 0;
        ap_start = 1'b1; command = 32'h4444_0004; data_num = 32'd512; axi00_ptr0 = P4;
        arready = 1'b1;
        step();
        ap_start = 1'b0;
        r_set(1'b1, 1'b1);
        step();
        r_set(1'b0, 1'b0);
        check("s_err", 64'(err_rlast), 64'd1);
        check("s_arvalid", 64'(arvalid), 64'd1);
        check("s_addr0", araddr, P4);
        for (int i = 0; i < 10; i++) step();
        check("o_hs4", 64'(hs_cnt), 64'd4);
        check("o_stall", 64'(arvalid), 64'd0);
        r_set(1'b1, 1'b1);
        step();
        r_set(1'b0, 1'b0);
        check("o_rel_valid", 64'(arvalid), 64'd1);
        check("o_rel_addr", araddr, P4 + 64'h4000);
        check("o_rel_len", 64'(arlen), 64'd63);
        step();
        for (int i = 0; i < 3; i++) step();
        check("o_hs5", 64'(hs_cnt), 64'd5);
        check("o_stall2", 64'(arvalid), 64'd0);

        // AR back-pressure with a start pulse that must be ignored
        arready = 1'b0;
        r_set(1'b1, 1'b1);
        step();
        r_set(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                ap_start = 1'b1; command = 32'hDEAD_BEEF; data_num = 32'd7; axi00_ptr0 = '0;
            end
            step();
            ap_start = 1'b0;
            check("bp_valid", 64'(arvalid), 64'd1);
            check("bp_addr", araddr, P4 + 64'h5000);
            check("bp_len", 64'(arlen), 64'd63);
        end
        check("bp_cmd", 64'(cmd_q), 64'h4444_0004);
        arready = 1'b1;
        step();
        check("bp_hs6", 64'(hs_cnt), 64'd6);
        check("bp_drop", 64'(arvalid), 64'd0);

        r_set(1'b1, 1'b1);
        step();
        r_set(1'b0, 1'b0);
        check("o_addr6", araddr, P4 + 64'h6000);
        step();
        r_set(1'b1, 1'b1);
        step();
        r_set(1'b0, 1'b0);
        check("o_addr7", araddr, P4 + 64'h7000);
        step();
        check("o_hs8", 64'(hs_cnt), 64'd8);
        check("o_drain_arvalid", 64'(arvalid), 64'd0);
        r_set(1'b1, 1'b1);
        step(); step();
        r_set(1'b0, 1'b0);
        step();
        check("d_not_idle", 64'(ap_idle), 64'd0);

        // Reset in DRAIN with two bursts outstanding
        ap_rst = 1'b1;
        step();
        ap_rst = 1'b0;
        check("r_idle", 64'(ap_idle), 64'd1);
        check("r_arvalid", 64'(arvalid), 64'd0);
        check("r_beats", 64'(beats_rcvd), 64'd0);
        check("r_err", 64'(err_rlast), 64'd0);
        check("r_no_done", 64'(done_cnt), 64'd0);

        // Fresh 64-beat transfer after the abort
        hs_cnt = 0; done_cnt = 0;
        ap_start = 1'b1; command = 32'h0000_0077; data_num = 32'd64; axi00_ptr0 = 64'h2000;
        step();
        ap_start = 1'b0;
        check("n_busy", 64'(ap_idle), 64'd0);
        step();
        check("n_valid", 64'(arvalid), 64'd1);
        check("n_addr", araddr, 64'h2000);
        check("n_len", 64'(arlen), 64'd63);
        step();
        check("n_drop", 64'(arvalid), 64'd0);
        check("n_hs", 64'(hs_cnt), 64'd1);
        for (int i = 1; i <= 64; i++) begin
            r_set(1'b1, i == 64);
            step();
        end
        r_set(1'b0, 1'b0);
        check("n_done_now", 64'(ap_done), 64'd1);
        step(); step();
        check("n_done_cnt", 64'(done_cnt), 64'd1);
        check("n_beats", 64'(beats_rcvd), 64'd64);
        check("n_idle", 64'(ap_idle), 64'd1);
        check("n_err", 64'(err_rlast), 64'd0);
        check("n_cmd", 64'(cmd_q), 64'h77);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
